// File: rtl/imem_fetch_ctrl_if.sv
// rtl/imem_fetch_ctrl_if.sv - fetch-stage and backing-memory signal bundle for imem_fetch_ctrl
interface imem_fetch_ctrl_if;
  logic [31:0] fetch_addr;
  logic        flush;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    input  fetch_addr, flush, mem_ack, mem_rdata,
    output instr, instr_valid, stall, mem_req, mem_addr, mem_err
  );

  modport slave (
    output fetch_addr, flush, mem_ack, mem_rdata,
    input  instr, instr_valid, stall, mem_req, mem_addr, mem_err
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - single-line instruction buffer with miss fill, flush and fill timeout
// Define IMEM_LINEBUF_EN for a 4-word line; left undefined the line is one word.
module imem_fetch_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  imem_fetch_ctrl_if.master bus
);

`ifdef IMEM_LINEBUF_EN
  localparam int LW   = 4;
  localparam int OFFW = 4;
`else
  localparam int LW   = 1;
  localparam int OFFW = 2;
`endif
  localparam int TAGW = 32 - OFFW;
  localparam int CW   = (LW > 1) ? $clog2(LW) : 1;
  localparam int WW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(LW - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, FILL} state_e;

  state_e          state_q, state_d;
  logic            valid_q, valid_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [TAGW-1:0] base_q, base_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [31:0]     instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic            mem_err_q, mem_err_d;
  logic [31:0]     line_q [LW];

  logic            line_we;
  logic            hit;
  logic            stall;
  logic            mem_req;
  logic [31:0]     sel_word;
  logic            unused_addr_bits;

`ifdef IMEM_LINEBUF_EN
  assign sel_word     = line_q[bus.fetch_addr[3:2]];
  assign bus.mem_addr = {base_q, cnt_q, 2'b00};
`else
  assign sel_word     = line_q[0];
  assign bus.mem_addr = {base_q, 2'b00};
`endif
  assign unused_addr_bits = ^bus.fetch_addr[1:0];

  assign hit = valid_q && (tag_q == bus.fetch_addr[31:OFFW]);

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    tag_d         = tag_q;
    base_d        = base_q;
    cnt_d         = cnt_q;
    wait_d        = wait_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    mem_err_d     = 1'b0;
    line_we       = 1'b0;
    stall         = 1'b0;
    mem_req       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          instr_d       = sel_word;
          instr_valid_d = !bus.flush;
        end else begin
          stall   = 1'b1;
          valid_d = 1'b0;
          base_d  = bus.fetch_addr[31:OFFW];
          cnt_d   = '0;
          wait_d  = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        // A flush here is deliberately ignored: the line always completes.
        if (bus.mem_ack) begin
          line_we = 1'b1;
          wait_d  = '0;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST_WORD) begin
            valid_d = 1'b1;
            tag_d   = base_q;
            state_d = IDLE;
          end
        end else if (wait_q == WAIT_LAST) begin
          mem_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      valid_q       <= 1'b0;
      tag_q         <= '0;
      base_q        <= '0;
      cnt_q         <= '0;
      wait_q        <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      mem_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      base_q        <= base_d;
      cnt_q         <= cnt_d;
      wait_q        <= wait_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      mem_err_q     <= mem_err_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LW; i++) begin
      if (!rst && line_we && (cnt_q == CW'(i))) begin
        line_q[i] <= bus.mem_rdata;
      end
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.stall       = stall;
  assign bus.mem_req     = mem_req;
  assign bus.mem_err     = mem_err_q;

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64: the maximum number of cycles mem_req may wait for mem_ack.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port fetch_addr, input, 32 bits: next-PC fetch address from the fetch stage.
REQ-005 The block SHALL have port flush, input, 1 bit: flush request from the hazard unit.
REQ-006 The block SHALL have port instr, output, 32 bits: the registered instruction word.
REQ-007 The block SHALL have port instr_valid, output, 1 bit: instr holds a valid word for the previous cycle's fetch_addr.
REQ-008 The block SHALL have port stall, output, 1 bit: hold-PC request to the hazard unit.
REQ-009 The block SHALL have port mem_req, output, 1 bit: backing-memory read request.
REQ-010 The block SHALL have port mem_addr, output, 32 bits: word-aligned backing-memory address, with bits [1:0] always 0.
REQ-011 The block SHALL have port mem_ack, input, 1 bit: backing-memory read accept, which also marks mem_rdata valid.
REQ-012 The block SHALL have port mem_rdata, input, 32 bits: backing-memory read data.
REQ-013 The block SHALL have port mem_err, output, 1 bit: one-cycle pulse on timeout.

Function
REQ-014 The block SHALL ignore fetch_addr[1:0] in all tag compares and word selection.
REQ-015 The line buffer SHALL hold one line plus a tag and a valid bit; a line is LW words (LW is set under Configuration).
REQ-016 The FSM SHALL have exactly two states: IDLE and FILL.
REQ-017 In IDLE, a hit (valid set and tag matching fetch_addr) SHALL register the selected word into instr, set instr_valid=1 on the next edge, and keep stall=0.
REQ-018 In IDLE, a miss SHALL drive stall=1 combinationally in the same cycle, clear valid, latch the line base and a word counter of 0, and enter FILL on the next edge with instr_valid=0.
REQ-019 In FILL:
- stall=1 and mem_req=1;
- mem_addr = line base + 4 × word counter;
- mem_addr SHALL stay stable while mem_req=1 and mem_ack=0.
REQ-020 On each cycle with mem_req=1 and mem_ack=1, the block SHALL write mem_rdata into the buffer at the word counter and increment the counter.
REQ-021 On the ack of the last word (counter = LW-1), the block SHALL:
- set valid and write the tag;
- return to IDLE with mem_req=0 on the next edge;
- serve the following cycle as a hit, since fetch_addr is held by the stall.
REQ-022 mem_ack SHALL be ignored while mem_req=0.
REQ-023 While in FILL, a wait counter SHALL count cycles without ack and clear on each ack.
REQ-024 When the wait counter reaches TIMEOUT_CYCLES-1 without ack, the block SHALL pulse mem_err=1 for one cycle, leave valid=0, drop mem_req, and return to IDLE.
REQ-025 A flush in IDLE SHALL force instr_valid=0 on the next edge, regardless of hit.
REQ-026 A flush in FILL SHALL NOT abort the fill; the line completes and instr_valid stays 0 until the next IDLE lookup.
REQ-027 When flush and the last-word ack occur in the same cycle, the line SHALL be installed and instr_valid SHALL be 0 on the next edge.
REQ-028 In IDLE, stall SHALL be 0 on a hit and 1 on a miss; in FILL, stall SHALL be 1.

Reset
REQ-029 On a rising clk edge with rst=1, the block SHALL set:
- state=IDLE;
- valid=0;
- instr=0 and instr_valid=0;
- mem_req=0 and mem_err=0;
- all counters to 0.
REQ-030 A reset asserted mid-FILL SHALL drop mem_req at that edge and discard the partial line; a late mem_ack after reset SHALL be ignored.

Configuration
REQ-031 When macro IMEM_LINEBUF_EN is defined, the block SHALL use LW=4 and tag = addr[31:4], with the word selected by addr[3:2].
REQ-032 When IMEM_LINEBUF_EN is undefined, the block SHALL use LW=1 and tag = addr[31:2]; each miss SHALL then issue exactly one memory request.

Verification
REQ-033 Scenario (reset): rst=1 for 2 cycles during FILL -> mem_req=0, instr_valid=0 and instr=0 next cycle; a mem_ack arriving 1 cycle later causes no buffer write.
REQ-034 Scenario (cold miss): fetch_addr=0x100 after reset with mem_ack 2 cycles after each req -> stall=1 same cycle, and mem_addr sequence depends on configuration:
- with IMEM_LINEBUF_EN: 0x100, 0x104, 0x108, 0x10C;
- without it: 0x100 only;
- in both cases, instr=mem_rdata(0x100) and instr_valid=1 one cycle after return to IDLE.
REQ-035 Scenario (hit streaming, IMEM_LINEBUF_EN): after the 0x100 fill, fetch_addr 0x104, 0x108, 0x10C on consecutive cycles -> stall=0 throughout and three consecutive valid words each 1 cycle later.
REQ-036 Scenario (timeout): TIMEOUT_CYCLES=8 and mem_ack held 0 -> mem_err high for exactly 1 cycle after 8 FILL cycles, followed by IDLE and then re-miss.
REQ-037 Scenario (flush collisions): flush on a hit cycle -> instr_valid=0 next cycle; flush coincident with the last-word ack -> line installed and instr_valid=0, then the next lookup at 0x100 hits.
REQ-038 Scenario (low-bit alias): fetch_addr=0x102 after the 0x100 line is installed -> hit returning the 0x100 word.
